// File: rtl/macguffin_pkg.sv
// Shared MacGuffin S-box definitions: DES-derived tables reduced to the outer two
// output bits, plus the state encoding of the sequential S-box layer.
package macguffin_pkg;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 2;

    typedef logic [SBOX_OUT_W-1:0] sbox_out_t;
    typedef sbox_out_t [0:7][0:63] sbox_tbl_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sbox_layer_state_t;

    // DES S1..S8, one 64-bit row per (box, row); nibble 0 (MSB) is column 0.
    localparam logic [0:7][0:3][63:0] DES_ROW = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Row = outer input bits, column = inner four; keep output bits 3 and 0.
    function automatic sbox_out_t des_reduce(input logic [2:0] box, input logic [5:0] x);
        logic [63:0] row_bits;
        logic [3:0]  nib;
        row_bits = DES_ROW[box][{x[5], x[0]}];
        nib      = row_bits[{~x[4:1], 2'b00} +: 4];
        return {nib[3], nib[0]};
    endfunction

    function automatic sbox_tbl_t gen_sbox_tbl();
        sbox_tbl_t t;
        for (int b = 0; b < 8; b++) begin
            for (int x = 0; x < 64; x++) begin
                t[b][x] = des_reduce(3'(b), 6'(x));
            end
        end
        return t;
    endfunction

    localparam sbox_tbl_t SBOX_TBL = gen_sbox_tbl();

endpackage

// File: rtl/mg_sbox_layer_if.sv
// Handshake bundle of the sequential S-box layer (iword in, oword out).
// With MG_SBOX_PARITY_EN defined the bundle also carries oword_par.
interface mg_sbox_layer_if #(
    parameter int NUM_SBOX = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6*NUM_SBOX-1:0] iword;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*NUM_SBOX-1:0] oword;
    logic                  busy;
`ifdef MG_SBOX_PARITY_EN
    logic                  oword_par;

    modport master (output in_valid, iword, out_ready,
                    input  in_ready, out_valid, oword, busy, oword_par);
    modport slave  (input  in_valid, iword, out_ready,
                    output in_ready, out_valid, oword, busy, oword_par);
`else
    modport master (output in_valid, iword, out_ready,
                    input  in_ready, out_valid, oword, busy);
    modport slave  (input  in_valid, iword, out_ready,
                    output in_ready, out_valid, oword, busy);
`endif
endinterface

// File: rtl/mg_sbox_lane.sv
// One combinational S-box lookup: selects table S<box+1> and maps 6 bits to 2.
module mg_sbox_lane
    import macguffin_pkg::*;
(
    input  logic [2:0]           box,
    input  logic [SBOX_IN_W-1:0] x,
    output sbox_out_t            y
);
    assign y = SBOX_TBL[box][x];
endmodule

// File: rtl/mg_sbox_layer.sv
// Sequential MacGuffin S-box layer: LANES lookups per cycle over NUM_SBOX/LANES chunks.
// Optional MG_SBOX_PARITY_EN adds oword_par (XOR of oword), registered with the last chunk.
module mg_sbox_layer
    import macguffin_pkg::*;
#(
    parameter int NUM_SBOX = 8,
    parameter int LANES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    mg_sbox_layer_if.slave bus
);
    localparam int C     = NUM_SBOX / LANES;
    localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
    localparam int IW    = SBOX_IN_W * NUM_SBOX;
    localparam int OW    = SBOX_OUT_W * NUM_SBOX;

    if (NUM_SBOX < 1 || NUM_SBOX > 8) begin : g_bad_num_sbox
        $error("mg_sbox_layer: NUM_SBOX must be in 1..8");
    end
    if (LANES < 1 || LANES > NUM_SBOX) begin : g_bad_lanes_range
        $error("mg_sbox_layer: LANES must be in 1..NUM_SBOX");
    end else if (NUM_SBOX % LANES != 0) begin : g_bad_lanes_div
        $error("mg_sbox_layer: LANES must divide NUM_SBOX");
    end

    sbox_layer_state_t state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last_chunk;
    logic              lookup_en;
    logic              accept;
    logic [IW-1:0]     in_reg;
    logic [OW-1:0]     oword_r;
    logic [OW-1:0]     oword_nxt;

    logic [2:0]           lane_box [LANES];
    logic [SBOX_IN_W-1:0] lane_x   [LANES];
    sbox_out_t            lane_y   [LANES];

    assign last_chunk = (cnt == CNT_W'(C - 1));
    assign accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = BUSY;
            BUSY:    if (last_chunk)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // in_ready depends on state alone so an upstream stage can never form a loop through it.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        lookup_en     = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            BUSY:    lookup_en     = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: bus.busy      = 1'b0;
        endcase
    end

    // Chunk k feeds boxes k*LANES .. k*LANES+LANES-1 to the lanes in order.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_box[j] = 3'd0;
            lane_x[j]   = '0;
        end
        for (int k = 0; k < C; k++) begin
            if (cnt == CNT_W'(k)) begin
                for (int j = 0; j < LANES; j++) begin
                    lane_box[j] = 3'(k * LANES + j);
                    lane_x[j]   = in_reg[SBOX_IN_W*(k*LANES+j) +: SBOX_IN_W];
                end
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        mg_sbox_lane u_lane (
            .box (lane_box[j]),
            .x   (lane_x[j]),
            .y   (lane_y[j])
        );
    end

    always_comb begin
        oword_nxt = oword_r;
        for (int k = 0; k < C; k++) begin
            if (cnt == CNT_W'(k)) begin
                for (int j = 0; j < LANES; j++) begin
                    oword_nxt[SBOX_OUT_W*(k*LANES+j) +: SBOX_OUT_W] = lane_y[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            in_reg  <= '0;
            oword_r <= '0;
        end else begin
            if (accept) in_reg <= bus.iword;
            if (lookup_en) begin
                oword_r <= oword_nxt;
                cnt     <= last_chunk ? '0 : cnt + 1'b1;
            end
        end
    end

    assign bus.oword = oword_r;

`ifdef MG_SBOX_PARITY_EN
    logic par_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          par_r <= 1'b0;
        else if (lookup_en && last_chunk) par_r <= ^oword_nxt;
    end

    assign bus.oword_par = par_r;
`endif

endmodule

// File: tb/tb_mg_sbox_layer.sv
// Bench for mg_sbox_layer: a 1-box/1-lane build and an 8-box/2-lane build side by side,
// table vectors plus random words scored through queues, backpressure and mid-run reset.
module tb_mg_sbox_layer;
    import macguffin_pkg::*;

    localparam int C8 = 4;
    localparam int C1 = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mg_sbox_layer_if #(.NUM_SBOX(8)) b8 ();
    mg_sbox_layer_if #(.NUM_SBOX(1)) b1 ();

    mg_sbox_layer #(.NUM_SBOX(8), .LANES(2)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    mg_sbox_layer #(.NUM_SBOX(1), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] q8[$];
    logic [1:0]  q1[$];

    typedef struct {
        logic [5:0] w;
        logic [1:0] e;
    } vec1_t;

    typedef struct {
        logic [47:0] w;
        logic [15:0] e;
    } vec8_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] model8(input logic [47:0] w);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) e[2*i +: 2] = SBOX_TBL[3'(i)][w[6*i +: 6]];
        return e;
    endfunction

    task automatic pop8();
        logic [15:0] e;
        if (q8.size() == 0) begin
            n_chk++;
            $display("FAIL sb8_empty: output with no expected word queued, got %0h", b8.oword);
        end else begin
            e = q8.pop_front();
            chk("oword8", b8.oword, e);
`ifdef MG_SBOX_PARITY_EN
            chk("par8", b8.oword_par, ^e);
`endif
        end
    endtask

    task automatic send8(input logic [47:0] w, input logic [15:0] e, input int bp);
        int n;
        b8.iword     = w;
        b8.in_valid  = 1'b1;
        b8.out_ready = (bp == 0);
        chk("in_ready8", b8.in_ready, 1);
        @(posedge clk); #1;
        q8.push_back(e);
        b8.iword    = ~w;
        b8.in_valid = (bp > 0);
        chk("busy8", b8.busy, 1);
        n = 0;
        while (!b8.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency8", n, C8);
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid8", b8.out_valid, 1);
            chk("bp_in_ready8", b8.in_ready, 0);
            chk("bp_oword8", b8.oword, q8[0]);
            @(posedge clk); #1;
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        pop8();
        @(posedge clk); #1;
        chk("in_ready_hs8", b8.in_ready, 1);
        chk("out_valid_hs8", b8.out_valid, 0);
        chk("hold8", b8.oword, e);
    endtask

    task automatic send1(input logic [5:0] w, input logic [1:0] e);
        int n;
        b1.iword     = w;
        b1.in_valid  = 1'b1;
        b1.out_ready = 1'b1;
        chk("in_ready1", b1.in_ready, 1);
        @(posedge clk); #1;
        q1.push_back(e);
        b1.iword    = ~w;
        b1.in_valid = 1'b0;
        n = 0;
        while (!b1.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", n, C1);
        if (q1.size() == 0) begin
            n_chk++;
            $display("FAIL sb1_empty: output with no expected value queued, got %0h", b1.oword);
        end else begin
            chk("oword1", b1.oword, q1.pop_front());
        end
        @(posedge clk); #1;
        chk("in_ready_hs1", b1.in_ready, 1);
    endtask

    task automatic reset_mid_busy(input logic [47:0] w);
        b8.iword     = w;
        b8.in_valid  = 1'b1;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("busy_chunk2", b8.busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_oword", b8.oword, 0);
        chk("rst_busy", b8.busy, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", b8.in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec1_t       t1 [6];
        vec8_t       t8 [3];
        logic [47:0] w;

        t1[0] = '{6'd0,  2'd2};
        t1[1] = '{6'd63, 2'd3};
        t1[2] = '{6'd3,  2'd3};
        t1[3] = '{6'd4,  2'd3};
        t1[4] = '{6'd5,  2'd1};
        t1[5] = '{6'd9,  2'd2};

        t8[0] = '{48'h0000_0000_0000, 16'hC86E};
        t8[1] = '{48'hFFFF_FFFF_FFFF, 16'hEDAF};
        t8[2] = '{48'hFFFF_FFFF_FFC0, 16'hEDAE};

        rst          = 1'b1;
        b8.in_valid  = 1'b0;
        b8.iword     = '0;
        b8.out_ready = 1'b1;
        b1.in_valid  = 1'b0;
        b1.iword     = '0;
        b1.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid8", b8.out_valid, 0);
        chk("reset_oword8", b8.oword, 0);
        chk("reset_busy8", b8.busy, 0);
        chk("reset_out_valid1", b1.out_valid, 0);
        chk("reset_oword1", b1.oword, 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready8", b8.in_ready, 1);
        chk("reset_in_ready1", b1.in_ready, 1);

        for (int i = 0; i < 6; i++) send1(t1[i].w, t1[i].e);
        for (int i = 0; i < 3; i++) send8(t8[i].w, t8[i].e, 0);

        for (int i = 0; i < 1000; i++) begin
            w = {16'($urandom), $urandom};
            send8(w, model8(w), 0);
        end

        w = {16'($urandom), $urandom};
        send8(w, model8(w), 10);

        for (int i = 0; i < 3; i++) begin
            w = {16'($urandom), $urandom};
            send8(w, model8(w), 0);
        end

        reset_mid_busy(48'h0123_4567_89AB);
        w = {16'($urandom), $urandom};
        send8(w, model8(w), 0);
        send8(48'h0000_0000_0000, 16'hC86E, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
